dpram_port_arbiter: RTL and testbench

- Shares one simple dual-port block RAM (port A write, port B read, fixed read latency) between several clients.
- Read port: round-robin arbitration among N_REQ readers. Each read response is routed back to its issuer after exactly N_DELAY cycles.
- Write port: fixed priority between two writers, the DMA loader (W0) and datapath writeback (W1).
- A same-address read/write collision guard keeps read data deterministic.
- Sits between the IFM/psum/filter buffer wrappers and their consumers.

---
 rtl/dpram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_dpram_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// Arbiter for one simple dual-port RAM. Writes use fixed priority with W0 first.
// Reads are round-robin with a same-address collision stall, and responses are routed back after N_DELAY cycles.
module dpram_port_arbiter #(
   parameter int DW      = 32,
   parameter int AW      = 16,
   parameter int N_REQ   = 4,
   parameter int N_DELAY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    rd_req,
   input  logic [N_REQ*AW-1:0] rd_addr,
   output logic [N_REQ-1:0]    rd_gnt,
   output logic [N_REQ-1:0]    rd_rsp_valid,
   output logic [DW-1:0]       rd_rsp_data,
   input  logic [1:0]          wr_req,
   input  logic [2*AW-1:0]     wr_addr,
   input  logic [2*DW-1:0]     wr_data,
   output logic [1:0]          wr_gnt,
   output logic                ram_ena,
   output logic                ram_wea,
   output logic [AW-1:0]       ram_addra,
   output logic [DW-1:0]       ram_dia,
   output logic                ram_enb,
   output logic [AW-1:0]       ram_addrb,
   input  logic [DW-1:0]       ram_dob
);
   localparam int PW = $clog2(N_REQ);
   localparam logic [PW:0]   N_REQ_W  = (PW+1)'(N_REQ);
   localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ-1);

   logic [PW-1:0]    rr_ptr_r;
   logic [N_REQ-1:0] rsp_pipe_r [N_DELAY];
   logic [AW-1:0]    rd_addr_s [N_REQ];
   logic             found_s;
   logic [PW-1:0]    cand_s;
   logic [PW:0]      scan_s;
   logic [AW-1:0]    cand_addr_s;
   logic             collide_s;

   // unpack reader addresses
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         rd_addr_s[i] = rd_addr[i*AW +: AW];
      end
   end

   // write port: W0 wins outright; addra/dia default to W0 when idle
   always_comb begin
      wr_gnt    = 2'b00;
      ram_addra = wr_addr[AW-1:0];
      ram_dia   = wr_data[DW-1:0];
      if (rst) begin
         wr_gnt = 2'b00;
      end else begin
         wr_gnt = {wr_req[1] & ~wr_req[0], wr_req[0]};
      end
      if (wr_gnt[1]) begin
         ram_addra = wr_addr[2*AW-1:AW];
         ram_dia   = wr_data[2*DW-1:DW];
      end else begin
         ram_addra = wr_addr[AW-1:0];
         ram_dia   = wr_data[DW-1:0];
      end
   end

   assign ram_ena = |wr_gnt;
   assign ram_wea = |wr_gnt;

   // round-robin scan from rr_ptr; the wrap is explicit so N_REQ need not be a power of two
   always_comb begin
      found_s = 1'b0;
      cand_s  = '0;
      scan_s  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_s = {1'b0, rr_ptr_r} + (PW+1)'(k);
         if (scan_s >= N_REQ_W) begin
            scan_s = scan_s - N_REQ_W;
         end else begin
            scan_s = scan_s;
         end
         if (!found_s && rd_req[scan_s[PW-1:0]]) begin
            found_s = 1'b1;
            cand_s  = scan_s[PW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign cand_addr_s = rd_addr_s[cand_s];
   assign collide_s   = ram_wea && (cand_addr_s == ram_addra);

   // read grant: the whole read port stalls if the candidate hits this cycle's write address
   always_comb begin
      rd_gnt    = '0;
      ram_enb   = 1'b0;
      ram_addrb = cand_addr_s;
      if (!rst && found_s && !collide_s) begin
         rd_gnt[cand_s] = 1'b1;
         ram_enb        = 1'b1;
      end else begin
         rd_gnt  = '0;
         ram_enb = 1'b0;
      end
   end

   // round-robin pointer advances past the granted reader
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r <= '0;
      end else if (ram_enb) begin
         rr_ptr_r <= (cand_s == LAST_IDX) ? '0 : cand_s + PW'(1);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // grant shift register matching the RAM read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_DELAY; k++) begin
            rsp_pipe_r[k] <= '0;
         end
      end else begin
         rsp_pipe_r[0] <= rd_gnt;
         for (int k = 1; k < N_DELAY; k++) begin
            rsp_pipe_r[k] <= rsp_pipe_r[k-1];
         end
      end
   end

   assign rd_rsp_valid = rsp_pipe_r[N_DELAY-1];
   assign rd_rsp_data  = ram_dob;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter. Two builds share one stimulus stream: N_REQ=4/N_DELAY=1 and N_REQ=3/N_DELAY=3.
// A behavioural RR/priority model is checked on every negedge, and literal pins are checked at key cycles.
module tb_dpram_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rd_req;
   logic [63:0] rd_addr;
   logic [1:0]  wr_req;
   logic [31:0] wr_addr;
   logic [63:0] wr_data;

   logic [3:0]  rd_gnt_a, rd_rsp_valid_a;
   logic [31:0] rd_rsp_data_a, ram_dia_a, ram_dob_a;
   logic [1:0]  wr_gnt_a;
   logic        ram_ena_a, ram_wea_a, ram_enb_a;
   logic [15:0] ram_addra_a, ram_addrb_a;

   logic [2:0]  rd_gnt_b, rd_rsp_valid_b;
   logic [31:0] rd_rsp_data_b, ram_dia_b, ram_dob_b;
   logic [1:0]  wr_gnt_b;
   logic        ram_ena_b, ram_wea_b, ram_enb_b;
   logic [15:0] ram_addra_b, ram_addrb_b;

   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   logic [31:0] pb1, pb2;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int ptr_a = 0;
   int ptr_b = 0;
   bit [3:0]    ev_a [4096];
   bit [2:0]    ev_b [4096];
   logic [31:0] ed_a [4096];
   logic [31:0] ed_b [4096];
   logic [31:0] ref_mem [256];

   bit          pin_ga_en, pin_gb_en, pin_va_en, pin_vb_en, pin_wg_en, pin_da_en, pin_db_en;
   logic [3:0]  pin_ga, pin_va;
   logic [2:0]  pin_gb, pin_vb;
   logic [1:0]  pin_wg;
   logic [31:0] pin_da, pin_db;

   always #5 clk = ~clk;

   dpram_port_arbiter #(.DW(32), .AW(16), .N_REQ(4), .N_DELAY(1)) dut_a (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_a),
      .rd_rsp_valid(rd_rsp_valid_a), .rd_rsp_data(rd_rsp_data_a), .wr_req(wr_req),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt_a), .ram_ena(ram_ena_a),
      .ram_wea(ram_wea_a), .ram_addra(ram_addra_a), .ram_dia(ram_dia_a), .ram_enb(ram_enb_a),
      .ram_addrb(ram_addrb_a), .ram_dob(ram_dob_a));

   dpram_port_arbiter #(.DW(32), .AW(16), .N_REQ(3), .N_DELAY(3)) dut_b (
      .clk(clk), .rst(rst), .rd_req(rd_req[2:0]), .rd_addr(rd_addr[47:0]), .rd_gnt(rd_gnt_b),
      .rd_rsp_valid(rd_rsp_valid_b), .rd_rsp_data(rd_rsp_data_b), .wr_req(wr_req),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt_b), .ram_ena(ram_ena_b),
      .ram_wea(ram_wea_b), .ram_addra(ram_addra_b), .ram_dia(ram_dia_b), .ram_enb(ram_enb_b),
      .ram_addrb(ram_addrb_b), .ram_dob(ram_dob_b));

   // RAM stand-ins: 1-cycle and 3-cycle read latency
   always @(posedge clk) begin
      if (ram_ena_a && ram_wea_a) mem_a[ram_addra_a[7:0]] <= ram_dia_a;
      if (ram_enb_a) ram_dob_a <= mem_a[ram_addrb_a[7:0]];
   end

   always @(posedge clk) begin
      if (ram_ena_b && ram_wea_b) mem_b[ram_addra_b[7:0]] <= ram_dia_b;
      if (ram_enb_b) pb1 <= mem_b[ram_addrb_b[7:0]];
      pb2       <= pb1;
      ram_dob_b <= pb2;
   end

   function automatic int pick(input int n, input int ptr, input logic [3:0] req);
      for (int k = 0; k < n; k++) begin
         int i;
         i = (ptr + k) % n;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [15:0] raddr(input logic [63:0] addrs, input int i);
      logic [63:0] t;
      t = addrs >> (16 * i);
      return t[15:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h, required %h", nm, cyc, act, exp);
      end
   endtask

   // model and compare, once per cycle away from the active edge
   always @(negedge clk) begin
      int          ca, cb;
      logic [1:0]  wg;
      logic [15:0] wa, ta, tb;
      logic [31:0] wd;
      logic [3:0]  ga;
      logic [2:0]  gb;
      wg = 2'b00;
      wa = wr_addr[15:0];
      wd = wr_data[31:0];
      ga = 4'b0000;
      gb = 3'b000;
      if (rst) begin
         ptr_a = 0;
         ptr_b = 0;
         for (int k = 0; k < 8; k++) begin
            ev_a[cyc+k] = 4'b0000;
            ev_b[cyc+k] = 3'b000;
         end
         ca = -1;
         cb = -1;
      end else begin
         if (wr_req[0]) wg = 2'b01;
         else if (wr_req[1]) wg = 2'b10;
         if (wg == 2'b10) begin
            wa = wr_addr[31:16];
            wd = wr_data[63:32];
         end
         ca = pick(4, ptr_a, rd_req);
         cb = pick(3, ptr_b, {1'b0, rd_req[2:0]});
         if (ca >= 0 && wg != 2'b00 && raddr(rd_addr, ca) == wa) ca = -1;
         if (cb >= 0 && wg != 2'b00 && raddr(rd_addr, cb) == wa) cb = -1;
      end
      if (ca >= 0) begin
         ga[ca] = 1'b1;
         ptr_a  = (ca + 1) % 4;
         ta     = raddr(rd_addr, ca);
         ed_a[cyc+1] = ref_mem[ta[7:0]];
      end
      if (cb >= 0) begin
         gb[cb] = 1'b1;
         ptr_b  = (cb + 1) % 3;
         tb     = raddr(rd_addr, cb);
         ed_b[cyc+3] = ref_mem[tb[7:0]];
      end
      if (!rst) begin
         ev_a[cyc+1] = ga;
         ev_b[cyc+3] = gb;
      end

      chk("rd_gnt_a", rd_gnt_a, ga);
      chk("ram_enb_a", ram_enb_a, |ga);
      if (ca >= 0) chk("ram_addrb_a", ram_addrb_a, ta);
      chk("rd_gnt_b", rd_gnt_b, gb);
      chk("ram_enb_b", ram_enb_b, |gb);
      if (cb >= 0) chk("ram_addrb_b", ram_addrb_b, tb);
      chk("wr_gnt_a", wr_gnt_a, wg);
      chk("wr_gnt_b", wr_gnt_b, wg);
      chk("ram_wea_a", {ram_ena_a, ram_wea_a}, {|wg, |wg});
      chk("ram_wea_b", {ram_ena_b, ram_wea_b}, {|wg, |wg});
      if (wg != 2'b00) begin
         chk("ram_addra_a", ram_addra_a, wa);
         chk("ram_dia_a", ram_dia_a, wd);
         chk("ram_addra_b", ram_addra_b, wa);
         chk("ram_dia_b", ram_dia_b, wd);
      end
      chk("rsp_valid_a", rd_rsp_valid_a, ev_a[cyc]);
      if (ev_a[cyc] != 4'b0000) chk("rsp_data_a", rd_rsp_data_a, ed_a[cyc]);
      chk("rsp_valid_b", rd_rsp_valid_b, ev_b[cyc]);
      if (ev_b[cyc] != 3'b000) chk("rsp_data_b", rd_rsp_data_b, ed_b[cyc]);

      if (pin_ga_en) begin
         chk("pin_rd_gnt_a", rd_gnt_a, pin_ga);
         chk("pin_model_gnt_a", ga, pin_ga);
      end
      if (pin_gb_en) begin
         chk("pin_rd_gnt_b", rd_gnt_b, pin_gb);
         chk("pin_model_gnt_b", gb, pin_gb);
      end
      if (pin_wg_en) begin
         chk("pin_wr_gnt", wr_gnt_a, pin_wg);
         chk("pin_model_wr_gnt", wg, pin_wg);
      end
      if (pin_va_en) chk("pin_rsp_valid_a", rd_rsp_valid_a, pin_va);
      if (pin_vb_en) chk("pin_rsp_valid_b", rd_rsp_valid_b, pin_vb);
      if (pin_da_en) chk("pin_rsp_data_a", rd_rsp_data_a, pin_da);
      if (pin_db_en) chk("pin_rsp_data_b", rd_rsp_data_b, pin_db);

      if (wg != 2'b00) ref_mem[wa[7:0]] = wd;
      cyc++;
   end

   task automatic next();
      @(posedge clk);
      #1;
      pin_ga_en = 1'b0; pin_gb_en = 1'b0; pin_va_en = 1'b0; pin_vb_en = 1'b0;
      pin_wg_en = 1'b0; pin_da_en = 1'b0; pin_db_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; rd_req = 4'h0; rd_addr = 64'h0; wr_req = 2'b00; wr_addr = 32'h0; wr_data = 64'h0;
      pin_ga_en = 1'b0; pin_gb_en = 1'b0; pin_va_en = 1'b0; pin_vb_en = 1'b0;
      pin_wg_en = 1'b0; pin_da_en = 1'b0; pin_db_en = 1'b0;
      pin_ga = 4'h0; pin_gb = 3'h0; pin_va = 4'h0; pin_vb = 3'h0; pin_wg = 2'b00;
      pin_da = 32'h0; pin_db = 32'h0;
      @(posedge clk); #1;
      repeat (3) begin
         rd_req = 4'hF; wr_req = 2'b11;
         pin_ga_en = 1'b1; pin_ga = 4'h0; pin_wg_en = 1'b1; pin_wg = 2'b00;
         next();
      end
      rst = 1'b0; rd_req = 4'h0; wr_req = 2'b00;

      // idle after reset
      for (int k = 0; k < 10; k++) begin
         pin_ga_en = 1'b1; pin_ga = 4'h0; pin_gb_en = 1'b1; pin_gb = 3'h0;
         pin_va_en = 1'b1; pin_va = 4'h0; pin_vb_en = 1'b1; pin_vb = 3'h0;
         next();
      end

      // preload mem[a] = a + 0x100 through W0
      for (int a = 16; a < 20; a++) begin
         wr_req = 2'b01; wr_addr = {16'h0000, 16'(a)}; wr_data = {32'h0, 32'(a + 256)};
         pin_wg_en = 1'b1; pin_wg = 2'b01;
         next();
      end
      wr_req = 2'b00;

      // all readers continuously: A grants 0,1,2,3,...; B grants 0,1,2,...
      rd_addr = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
      for (int k = 0; k < 8; k++) begin
         rd_req = 4'hF;
         pin_ga_en = 1'b1; pin_ga = 4'(1 << (k % 4));
         pin_gb_en = 1'b1; pin_gb = 3'(1 << (k % 3));
         pin_va_en = 1'b1; pin_va = (k == 0) ? 4'h0 : 4'(1 << ((k - 1) % 4));
         if (k > 0) begin
            pin_da_en = 1'b1; pin_da = 32'h110 + 32'((k - 1) % 4);
         end
         next();
      end
      rd_req = 4'h0;
      repeat (4) next();

      // reader 2 alone for three cycles; 3-cycle build answers three cycles later
      for (int k = 0; k < 6; k++) begin
         rd_req = (k < 3) ? 4'b0100 : 4'b0000;
         pin_gb_en = 1'b1; pin_gb = (k < 3) ? 3'b100 : 3'b000;
         pin_ga_en = 1'b1; pin_ga = (k < 3) ? 4'b0100 : 4'b0000;
         pin_vb_en = 1'b1; pin_vb = (k >= 3) ? 3'b100 : 3'b000;
         if (k >= 3) begin
            pin_db_en = 1'b1; pin_db = 32'h112;
         end
         next();
      end

      // both writers, then W1 alone, then read both back
      wr_req = 2'b11; wr_addr = {16'h0021, 16'h0020}; wr_data = {32'hBBBB0021, 32'hAAAA0020};
      pin_wg_en = 1'b1; pin_wg = 2'b01;
      next();
      wr_req = 2'b10;
      pin_wg_en = 1'b1; pin_wg = 2'b10;
      next();
      wr_req = 2'b00;
      rd_addr = {16'h0013, 16'h0012, 16'h0021, 16'h0020};
      rd_req = 4'b0011; pin_ga_en = 1'b1; pin_ga = 4'b0001;
      next();
      rd_req = 4'b0011; pin_ga_en = 1'b1; pin_ga = 4'b0010;
      pin_va_en = 1'b1; pin_va = 4'b0001; pin_da_en = 1'b1; pin_da = 32'hAAAA0020;
      next();
      rd_req = 4'b0000;
      pin_va_en = 1'b1; pin_va = 4'b0010; pin_da_en = 1'b1; pin_da = 32'hBBBB0021;
      next();
      repeat (3) next();

      // collision: reader 0 once (pointer to 1), then reader 1 reads 0x30 as W0 writes it
      rd_addr = {16'h0013, 16'h0012, 16'h0030, 16'h0010};
      rd_req = 4'b0001; pin_ga_en = 1'b1; pin_ga = 4'b0001;
      next();
      rd_req = 4'b0010; wr_req = 2'b01; wr_addr = {16'h0000, 16'h0030}; wr_data = {32'h0, 32'hC0FFEE30};
      pin_ga_en = 1'b1; pin_ga = 4'b0000; pin_gb_en = 1'b1; pin_gb = 3'b000;
      next();
      wr_req = 2'b00;
      pin_ga_en = 1'b1; pin_ga = 4'b0010; pin_gb_en = 1'b1; pin_gb = 3'b010;
      next();
      rd_req = 4'b0000;
      pin_va_en = 1'b1; pin_va = 4'b0010; pin_da_en = 1'b1; pin_da = 32'hC0FFEE30;
      next();
      repeat (3) next();

      // pointer wrap: last reader granted, then reader 0 wins immediately
      rd_addr = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
      rd_req = 4'b0100; pin_ga_en = 1'b1; pin_ga = 4'b0100; pin_gb_en = 1'b1; pin_gb = 3'b100;
      next();
      rd_req = 4'b1000; pin_ga_en = 1'b1; pin_ga = 4'b1000; pin_gb_en = 1'b1; pin_gb = 3'b000;
      next();
      rd_req = 4'b0111; pin_ga_en = 1'b1; pin_ga = 4'b0001; pin_gb_en = 1'b1; pin_gb = 3'b001;
      next();

      // reset in the middle of a burst drops in-flight reads
      repeat (3) begin
         rd_req = 4'hF;
         next();
      end
      rst = 1'b1;
      pin_va_en = 1'b1; pin_va = 4'h0; pin_vb_en = 1'b1; pin_vb = 3'h0;
      pin_ga_en = 1'b1; pin_ga = 4'h0; pin_gb_en = 1'b1; pin_gb = 3'h0;
      next();
      rst = 1'b0; rd_req = 4'h0;
      repeat (4) begin
         pin_va_en = 1'b1; pin_va = 4'h0; pin_vb_en = 1'b1; pin_vb = 3'h0;
         next();
      end
      rd_req = 4'hF; pin_ga_en = 1'b1; pin_ga = 4'b0001; pin_gb_en = 1'b1; pin_gb = 3'b001;
      next();
      rd_req = 4'h0;
      repeat (4) next();

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
